// File: rtl/cam_ctrl.sv
// cam_ctrl -- command sequencer for an external CAM.
//
// Accepts SEARCH / INSERT / DELETE / CLEAR commands and drives the CAM write
// port and search key. It keeps its own occupancy bitmap, which is used to pick
// the lowest free slot on INSERT. After reset it invalidates every CAM entry
// before it accepts the first command.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   cmd_valid     command request;    cmd_ready  high only while idle
//   cmd_op        00 SEARCH, 01 INSERT, 10 DELETE, 11 CLEAR
//   cmd_data      command key
//   rsp_valid     response available; rsp_ready  consumes it
//   rsp_status    00 OK, 01 MISS, 10 DUP, 11 FULL
//   rsp_addr      matched or written index
//   cam_we        CAM write strobe, with cam_addr / cam_data / cam_valid
//   lookup_data   CAM search key (the registered command key)
//   lookup_addr   CAM match index, 1-cycle registered latency
//   lookup_hit    CAM match flag,  1-cycle registered latency
//   used_count    number of occupied entries
//   full          all entries occupied
`timescale 1ns/1ps
module cam_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_status,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  cam_we,
  output logic [ADDR_WIDTH-1:0] cam_addr,
  output logic [DATA_WIDTH-1:0] cam_data,
  output logic                  cam_valid,
  output logic [DATA_WIDTH-1:0] lookup_data,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  input  logic                  lookup_hit,
  output logic [ADDR_WIDTH:0]   used_count,
  output logic                  full
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_MISS = 2'b01;
  localparam logic [1:0] ST_DUP  = 2'b10;
  localparam logic [1:0] ST_FULL = 2'b11;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_EVAL, S_WRITE, S_CLEAR, S_RESP
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH:0]     sweep_q;
  logic [DEPTH-1:0]        bitmap_q;
  logic [1:0]              op_q;
  logic [DATA_WIDTH-1:0]   key_q;
  logic                    cmd_ready_q;
  logic                    rsp_valid_q;
  logic [1:0]              rsp_status_q;
  logic [ADDR_WIDTH-1:0]   rsp_addr_q;
  logic                    cam_we_q;
  logic [ADDR_WIDTH-1:0]   cam_addr_q;
  logic [DATA_WIDTH-1:0]   cam_data_q;
  logic                    cam_valid_q;

  function automatic logic [ADDR_WIDTH:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_WIDTH:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + (ADDR_WIDTH+1)'(v[i]);
    return c;
  endfunction

  // Scans from the top down so the last assignment is the lowest free index.
  function automatic logic [ADDR_WIDTH-1:0] lowest_free(input logic [DEPTH-1:0] v);
    logic [ADDR_WIDTH-1:0] idx;
    idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!v[i]) idx = ADDR_WIDTH'(i);
    end
    return idx;
  endfunction

  assign used_count  = popcount(bitmap_q);
  assign full        = (used_count == DEPTH_C);
  assign lookup_data = key_q;
  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_status  = rsp_status_q;
  assign rsp_addr    = rsp_addr_q;
  assign cam_we      = cam_we_q;
  assign cam_addr    = cam_addr_q;
  assign cam_data    = cam_data_q;
  assign cam_valid   = cam_valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_INIT;
      sweep_q      <= '0;
      bitmap_q     <= '0;
      op_q         <= OP_SEARCH;
      key_q        <= '0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= ST_OK;
      rsp_addr_q   <= '0;
      cam_we_q     <= 1'b0;
      cam_addr_q   <= '0;
      cam_data_q   <= '0;
      cam_valid_q  <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse unless a state re-asserts it.
      cam_we_q <= 1'b0;
      case (state_q)
        // INIT spends its first cycle idle (outputs come out of reset at 0);
        // CLEAR issues address 0 on the accept edge, so both produce DEPTH
        // invalidating writes before leaving.
        S_INIT, S_CLEAR: begin
          if (sweep_q == DEPTH_C) begin
            sweep_q  <= '0;
            bitmap_q <= '0;
            if (state_q == S_INIT) begin
              state_q     <= S_IDLE;
              cmd_ready_q <= 1'b1;
            end else begin
              state_q      <= S_RESP;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= ST_OK;
              rsp_addr_q   <= '0;
            end
          end else begin
            cam_we_q    <= 1'b1;
            cam_addr_q  <= sweep_q[ADDR_WIDTH-1:0];
            cam_data_q  <= '0;
            cam_valid_q <= 1'b0;
            sweep_q     <= sweep_q + 1'b1;
          end
        end

        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            op_q        <= cmd_op;
            key_q       <= cmd_data;
            if (cmd_op == OP_CLEAR) begin
              state_q     <= S_CLEAR;
              cam_we_q    <= 1'b1;
              cam_addr_q  <= '0;
              cam_data_q  <= '0;
              cam_valid_q <= 1'b0;
              sweep_q     <= (ADDR_WIDTH+1)'(1);
              bitmap_q    <= '0;
            end else begin
              state_q <= S_LOOKUP;
            end
          end
        end

        // lookup_data has been driven since the accept edge; the CAM result
        // appears one cycle later, in EVAL.
        S_LOOKUP: state_q <= S_EVAL;

        S_EVAL: begin
          case (op_q)
            OP_INSERT: begin
              if (lookup_hit) begin
                state_q      <= S_RESP;
                rsp_valid_q  <= 1'b1;
                rsp_status_q <= ST_DUP;
                rsp_addr_q   <= lookup_addr;
              end else if (full) begin
                state_q      <= S_RESP;
                rsp_valid_q  <= 1'b1;
                rsp_status_q <= ST_FULL;
                rsp_addr_q   <= '0;
              end else begin
                state_q     <= S_WRITE;
                cam_we_q    <= 1'b1;
                cam_addr_q  <= lowest_free(bitmap_q);
                cam_data_q  <= key_q;
                cam_valid_q <= 1'b1;
              end
            end
            OP_DELETE: begin
              if (lookup_hit) begin
                state_q     <= S_WRITE;
                cam_we_q    <= 1'b1;
                cam_addr_q  <= lookup_addr;
                cam_data_q  <= key_q;
                cam_valid_q <= 1'b0;
              end else begin
                state_q      <= S_RESP;
                rsp_valid_q  <= 1'b1;
                rsp_status_q <= ST_MISS;
                rsp_addr_q   <= '0;
              end
            end
            default: begin
              state_q      <= S_RESP;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= lookup_hit ? ST_OK : ST_MISS;
              rsp_addr_q   <= lookup_hit ? lookup_addr : '0;
            end
          endcase
        end

        // The write strobe is already on the CAM port; the occupancy bit
        // follows on this edge so used_count tracks completed writes.
        S_WRITE: begin
          bitmap_q[cam_addr_q] <= cam_valid_q;
          state_q              <= S_RESP;
          rsp_valid_q          <= 1'b1;
          rsp_status_q         <= ST_OK;
          rsp_addr_q           <= cam_addr_q;
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_INIT;
          sweep_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_ctrl.sv
`timescale 1ns/1ps
module tb_cam_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  localparam logic [1:0] OP_S = 2'b00, OP_I = 2'b01, OP_D = 2'b10, OP_C = 2'b11;
  localparam logic [1:0] ST_OK = 2'b00, ST_MISS = 2'b01, ST_DUP = 2'b10, ST_FULL = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_status;
  logic [AW-1:0] rsp_addr;
  logic          cam_we;
  logic [AW-1:0] cam_addr;
  logic [DW-1:0] cam_data;
  logic          cam_valid;
  logic [DW-1:0] lookup_data;
  logic [AW-1:0] lookup_addr;
  logic          lookup_hit;
  logic [AW:0]   used_count;
  logic          full;

  always #5 clk = ~clk;

  cam_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_addr(rsp_addr),
    .cam_we(cam_we), .cam_addr(cam_addr), .cam_data(cam_data), .cam_valid(cam_valid),
    .lookup_data(lookup_data), .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
    .used_count(used_count), .full(full)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // External CAM model: registered lookup, lowest matching index wins.
  // Starts with stale valid entries so that a missing invalidation sweep shows up.
  logic [DW-1:0] cam_mem [DEPTH];
  logic          cam_v   [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      cam_mem[i] = DW'(i);
      cam_v[i]   = 1'b1;
    end
    lookup_hit  = 1'b0;
    lookup_addr = '0;
  end

  always @(posedge clk) begin : cam_model
    logic          h;
    logic [AW-1:0] a;
    h = 1'b0;
    a = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (cam_v[i] && cam_mem[i] == lookup_data) begin
        h = 1'b1;
        a = AW'(i);
      end
    end
    lookup_hit  <= h;
    lookup_addr <= a;
    if (cam_we) begin
      cam_mem[cam_addr] <= cam_data;
      cam_v[cam_addr]   <= cam_valid;
    end
  end

  // Log of CAM write strobes.
  typedef struct { logic [AW-1:0] a; logic v; logic [DW-1:0] d; } wr_t;
  wr_t wlog [$];

  always @(negedge clk) begin
    if (cam_we === 1'b1) wlog.push_back('{a: cam_addr, v: cam_valid, d: cam_data});
  end

  // Scoreboard: expected status, address and latency (cycles counted including
  // the accept cycle, so t0 is the negedge just before the accept edge).
  typedef struct { logic [1:0] st; logic [AW-1:0] addr; int lat; time t0; } exp_t;
  exp_t exp_q [$];
  logic rsp_valid_prev = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    int   lat;
    if (rsp_valid === 1'b1 && rsp_valid_prev !== 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: status=%0d addr=%0d with no command outstanding", rsp_status, rsp_addr);
      end else begin
        e   = exp_q.pop_front();
        lat = int'(($time - e.t0) / 10);
        if (rsp_status !== e.st) begin
          n_fail++;
          $display("FAIL rsp_status: got %0d expected %0d", rsp_status, e.st);
        end
        n_checks++;
        if (rsp_addr !== e.addr) begin
          n_fail++;
          $display("FAIL rsp_addr: got %0d expected %0d", rsp_addr, e.addr);
        end
        n_checks++;
        if (lat != e.lat) begin
          n_fail++;
          $display("FAIL rsp_latency: got %0d expected %0d", lat, e.lat);
        end
      end
    end
    rsp_valid_prev = rsp_valid;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Returns at a negedge with cmd_ready high, or flags a timeout.
  task automatic wait_ready(input string nm);
    int n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(cmd_ready), 64'(1));
  endtask

  task automatic issue(input logic [1:0] op, input logic [DW-1:0] d, input bit expect_rsp,
                       input logic [1:0] st, input logic [AW-1:0] ad, input int lat);
    exp_t e;
    wait_ready("cmd_accept");
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    if (expect_rsp) begin
      e.st = st; e.addr = ad; e.lat = lat; e.t0 = $time;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic check_sweep(input string nm);
    int bad = 0;
    chk({nm, "_count"}, 64'(wlog.size()), 64'(DEPTH));
    foreach (wlog[i]) begin
      if (wlog[i].a !== AW'(i) || wlog[i].v !== 1'b0) bad++;
    end
    chk({nm, "_order"}, 64'(bad), 64'(0));
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_S;
    cmd_data  = '0;
    rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready",  64'(cmd_ready), 64'(0));
    chk("rst_rsp_valid",  64'(rsp_valid), 64'(0));
    chk("rst_rsp",        64'({rsp_status, rsp_addr}), 64'(0));
    chk("rst_cam_we",     64'(cam_we), 64'(0));
    chk("rst_cam_port",   64'({cam_addr, cam_valid, cam_data}), 64'(0));
    chk("rst_lookup",     64'(lookup_data), 64'(0));
    chk("rst_used",       64'(used_count), 64'(0));
    chk("rst_full",       64'(full), 64'(0));

    // Power-up invalidation sweep.
    wlog.delete();
    reset = 1'b1;
    wait_ready("init_done");
    check_sweep("init_sweep");
    chk("init_used", 64'(used_count), 64'(0));

    // Insert then search.
    wlog.delete();
    issue(OP_I, 32'hDEADBEEF, 1, ST_OK, 5'd0, 4);
    wait_ready("ins1_done");
    chk("ins1_wr_count", 64'(wlog.size()), 64'(1));
    if (wlog.size() > 0)
      chk("ins1_wr", 64'({wlog[0].a, wlog[0].v, wlog[0].d}), 64'({5'd0, 1'b1, 32'hDEADBEEF}));
    chk("ins1_used", 64'(used_count), 64'(1));
    issue(OP_S, 32'hDEADBEEF, 1, ST_OK, 5'd0, 3);
    issue(OP_S, 32'h1, 1, ST_MISS, 5'd0, 3);

    // Duplicate insert.
    issue(OP_C, '0, 1, ST_OK, 5'd0, DEPTH+1);
    wait_ready("clr1_done");
    chk("clr1_used", 64'(used_count), 64'(0));
    issue(OP_I, 32'hA, 1, ST_OK, 5'd0, 4);
    issue(OP_I, 32'hA, 1, ST_DUP, 5'd0, 3);
    wait_ready("dup_done");
    chk("dup_used", 64'(used_count), 64'(1));

    // Delete of an absent key writes nothing.
    wlog.delete();
    issue(OP_D, 32'h55, 1, ST_MISS, 5'd0, 3);
    wait_ready("delmiss_done");
    chk("delmiss_no_we", 64'(wlog.size()), 64'(0));
    chk("delmiss_used", 64'(used_count), 64'(1));

    // Fill to capacity, overflow, delete a hole, refill the hole.
    issue(OP_C, '0, 1, ST_OK, 5'd0, DEPTH+1);
    for (int i = 0; i < DEPTH; i++) issue(OP_I, 32'h100 + i, 1, ST_OK, AW'(i), 4);
    wait_ready("fill_done");
    chk("fill_full", 64'(full), 64'(1));
    chk("fill_used", 64'(used_count), 64'(DEPTH));
    issue(OP_I, 32'h999, 1, ST_FULL, 5'd0, 3);
    issue(OP_I, 32'h105, 1, ST_DUP, 5'd5, 3);
    issue(OP_D, 32'h107, 1, ST_OK, 5'd7, 4);
    wait_ready("hole_done");
    chk("hole_full", 64'(full), 64'(0));
    chk("hole_used", 64'(used_count), 64'(DEPTH-1));
    issue(OP_I, 32'h777, 1, ST_OK, 5'd7, 4);
    issue(OP_S, 32'h777, 1, ST_OK, 5'd7, 3);
    issue(OP_S, 32'h107, 1, ST_MISS, 5'd0, 3);
    wait_ready("refill_done");
    chk("refill_used", 64'(used_count), 64'(DEPTH));

    // CLEAR with five live entries.
    issue(OP_C, '0, 1, ST_OK, 5'd0, DEPTH+1);
    for (int i = 0; i < 5; i++) issue(OP_I, 32'h200 + i, 1, ST_OK, AW'(i), 4);
    wait_ready("five_done");
    chk("five_used", 64'(used_count), 64'(5));
    wlog.delete();
    issue(OP_C, '0, 1, ST_OK, 5'd0, DEPTH+1);
    wait_ready("clr5_done");
    check_sweep("clr5_sweep");
    chk("clr5_used", 64'(used_count), 64'(0));
    issue(OP_S, 32'h202, 1, ST_MISS, 5'd0, 3);

    // Response back-pressure.
    issue(OP_I, 32'h3C3C, 1, ST_OK, 5'd0, 4);
    wait_ready("bp_ins_done");
    rsp_ready = 1'b0;
    issue(OP_S, 32'h3C3C, 1, ST_OK, 5'd0, 3);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_seen", 64'(rsp_valid), 64'(1));
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold", 64'({rsp_valid, rsp_status, rsp_addr, cmd_ready}), 64'({1'b1, ST_OK, 5'd0, 1'b0}));
    end
    rsp_ready = 1'b1;
    wait_ready("bp_release");

    // Reset in the middle of a CLEAR restarts the full sweep.
    issue(OP_C, '0, 0, ST_OK, 5'd0, 0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    wlog.delete();
    chk("midrst_we", 64'(cam_we), 64'(0));
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    wait_ready("reinit_done");
    check_sweep("reinit_sweep");
    chk("reinit_used", 64'(used_count), 64'(0));
    issue(OP_S, 32'h3C3C, 1, ST_MISS, 5'd0, 3);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
